// File: rtl/tlul_pkg.sv
// TileLink-UL request/response channel types and opcode encodings
// shared by the SRAM responder and its hosts.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef logic [15:0] tl_d_user_t;
  localparam tl_d_user_t TL_D_USER_DEFAULT = 16'h0000;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_responder.sv
// TL-UL device bridging to a single-port SRAM with one-cycle read latency;
// two-entry response buffer so a_ready can be registered.
module tlul_sram_responder
  import tlul_pkg::*;
#(
  parameter int SramAw   = 12,
  parameter int ErrOnOor = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic [31:0]       sram_wmask_o,
  input  logic [31:0]       sram_rdata_i
);

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] size;
    logic [7:0] source;
    logic       error;
  } rsp_t;

  rsp_t        rsp_q  [2];
  logic [31:0] data_q [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count, count_d;
  logic        a_ready_q;
  logic        rd_pend_q;   // a Get issued to the SRAM last cycle
  logic        rd_slot_q;   // slot waiting for that read data

  logic is_get, is_put, bad_op, oor, req_err, a_ack, d_ack, d_valid;
  logic unused_param;

  assign unused_param = ^tl_i.a_param;

  assign is_get  = (tl_i.a_opcode == Get);
  assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign bad_op  = !(is_get || is_put);
  assign oor     = (ErrOnOor != 0) && ((tl_i.a_address >> (SramAw + 2)) != 32'd0);
  assign req_err = bad_op || (tl_i.a_address[1:0] != 2'b00) || (tl_i.a_size > 2'd2) || oor;

  assign a_ack   = tl_i.a_valid && a_ready_q;
  assign d_valid = (count != 2'd0);
  assign d_ack   = d_valid && tl_i.d_ready;
  assign count_d = count + 2'(a_ack) - 2'(d_ack);

  // Errored requests never touch the SRAM.
  assign sram_req_o   = a_ack && !req_err;
  assign sram_we_o    = sram_req_o && is_put;
  assign sram_addr_o  = tl_i.a_address[SramAw+1:2];
  assign sram_wdata_o = tl_i.a_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sram_wmask_o = '0;
    for (int i = 0; i < 4; i++) begin
      sram_wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. The small
  // response storage is reset too, since its contents are visible on the
  // D channel while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        rsp_q[i]  <= '0;
        data_q[i] <= '0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      a_ready_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_slot_q <= 1'b0;
    end else begin
      if (a_ack) begin
        rsp_q[wr_ptr].opcode <= is_get ? AccessAckData : AccessAck;
        rsp_q[wr_ptr].size   <= tl_i.a_size;
        rsp_q[wr_ptr].source <= tl_i.a_source;
        rsp_q[wr_ptr].error  <= req_err;
        data_q[wr_ptr]       <= '0;
        wr_ptr               <= ~wr_ptr;
      end
      // The slot being filled by a read can never be the one a new accept
      // writes in the same cycle: either it is still occupied or the
      // write pointer has already moved past it.
      if (rd_pend_q) begin
        data_q[rd_slot_q] <= sram_rdata_i;
      end
      rd_pend_q <= sram_req_o && !sram_we_o;
      rd_slot_q <= wr_ptr;
      if (d_ack) begin
        rd_ptr <= ~rd_ptr;
      end
      count     <= count_d;
      a_ready_q <= (count_d < 2'd2);
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready_q;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = rsp_q[rd_ptr].opcode;
    tl_o.d_size   = rsp_q[rd_ptr].size;
    tl_o.d_source = rsp_q[rd_ptr].source;
    tl_o.d_error  = rsp_q[rd_ptr].error;
    tl_o.d_user   = TL_D_USER_DEFAULT;
    // Read data is forwarded live in its arrival cycle, then from the capture.
    tl_o.d_data   = (rd_pend_q && (rd_slot_q == rd_ptr)) ? sram_rdata_i : data_q[rd_ptr];
  end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Self-checking bench: randomized TL-UL traffic against a queue-based model
// of the responder, plus directed scenarios with literal expectations.
module tb_tlul_sram_responder;
  import tlul_pkg::*;

  localparam int AW = 12;
  localparam int NW = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_ni;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_wmask, sram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlul_sram_responder #(.SramAw(AW), .ErrOnOor(1)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .tl_i         (tl_i),
    .tl_o         (tl_o),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_wmask_o (sram_wmask),
    .sram_rdata_i (sram_rdata)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // SRAM environment: one-cycle read latency, garbage on idle cycles.
  logic [31:0] sram_mem [NW];
  initial begin
    for (int i = 0; i < NW; i++) sram_mem[i] = 32'h0;
    sram_mem[0] = 32'h0000_0013;
    sram_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      if (sram_req && sram_we) begin
        sram_mem[sram_addr] = (sram_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      end
      if (sram_req && !sram_we) sram_rdata <= sram_mem[sram_addr];
      else                      sram_rdata <= $urandom();
    end
  end

  // Reference model: expected responses in acceptance order.
  typedef struct {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        error;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ref_mem [NW];

  initial begin
    exp_t        e;
    logic        stall_prev;
    logic [31:0] snap_data;
    logic [7:0]  snap_src;
    logic [2:0]  snap_op;
    logic        snap_err;
    logic        err, get, put;
    logic [31:0] m;
    int          w;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    ref_mem[0] = 32'h0000_0013;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        check("rst_a_ready",  tl_o.a_ready,  1'b0);
        check("rst_d_valid",  tl_o.d_valid,  1'b0);
        check("rst_sram_req", sram_req,      1'b0);
        check("rst_sram_we",  sram_we,       1'b0);
        check("rst_d_fields", {tl_o.d_opcode, tl_o.d_param, tl_o.d_size, tl_o.d_source,
                               tl_o.d_sink, tl_o.d_error}, 64'h0);
        check("rst_d_data",   tl_o.d_data,   32'h0);
        check("rst_d_user",   tl_o.d_user,   TL_D_USER_DEFAULT);
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        check("a_ready", tl_o.a_ready, exp_q.size() < 2);
        check("d_valid", tl_o.d_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("d_opcode", tl_o.d_opcode, e.opcode);
          check("d_size",   tl_o.d_size,   e.size);
          check("d_source", tl_o.d_source, e.source);
          check("d_error",  tl_o.d_error,  e.error);
          check("d_data",   tl_o.d_data,   e.data);
          check("d_const",  {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, {3'h0, 1'b0, TL_D_USER_DEFAULT});
        end
        if (stall_prev && tl_o.d_valid) begin
          check("stall_stable", {tl_o.d_data, tl_o.d_source, tl_o.d_opcode, tl_o.d_error},
                                {snap_data, snap_src, snap_op, snap_err});
        end
        stall_prev = tl_o.d_valid && !tl_i.d_ready;
        snap_data  = tl_o.d_data;
        snap_src   = tl_o.d_source;
        snap_op    = tl_o.d_opcode;
        snap_err   = tl_o.d_error;

        if (tl_o.d_valid && tl_i.d_ready && exp_q.size() != 0) void'(exp_q.pop_front());

        if (tl_i.a_valid && tl_o.a_ready) begin
          get = (tl_i.a_opcode == 3'd4);
          put = (tl_i.a_opcode == 3'd0) || (tl_i.a_opcode == 3'd1);
          err = !(get || put) || (tl_i.a_address % 4 != 0) || (tl_i.a_size == 2'd3) ||
                (tl_i.a_address >= 32'(4 * NW));
          w = int'(tl_i.a_address / 4) % NW;
          check("sram_req", sram_req, !err);
          if (!err) begin
            m = 32'h0;
            for (int b = 0; b < 4; b++) if (tl_i.a_mask[b]) m = m | (32'hFF << (8 * b));
            check("sram_we",    sram_we,    put);
            check("sram_addr",  sram_addr,  w);
            check("sram_wdata", sram_wdata, tl_i.a_data);
            check("sram_wmask", sram_wmask, m);
          end
          e.opcode = get ? 3'd1 : 3'd0;
          e.size   = tl_i.a_size;
          e.source = tl_i.a_source;
          e.error  = err;
          e.data   = (get && !err) ? ref_mem[w] : 32'h0;
          if (put && !err) ref_mem[w] = (ref_mem[w] & ~m) | (tl_i.a_data & m);
          exp_q.push_back(e);
        end else begin
          check("sram_idle", sram_req, 1'b0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'h0;
    tl_i.a_size    = size;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
  endtask

  // Drive one request until accepted; returns the SRAM strobes seen in the accept cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [7:0] src,
                       output logic req, output logic we, output logic [31:0] wmask);
    logic ok;
    ok = 1'b0;
    req = 1'b0; we = 1'b0; wmask = 32'h0;
    set_req(op, addr, 2'd2, mask, data, src);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (tl_o.a_ready) begin
        ok = 1'b1; req = sram_req; we = sram_we; wmask = sram_wmask;
      end
    end
    check("accept_timeout", ok, 1'b1);
    tick();
    tl_i.a_valid = 1'b0;
  endtask

  task automatic rand_req();
    int          r, word;
    logic [2:0]  op;
    logic [31:0] addr;
    r = $urandom_range(0, 9);
    op = (r < 5) ? 3'd4 : (r == 5) ? 3'd0 : (r == 6) ? 3'd1 : 3'($urandom_range(0, 7));
    word = $urandom_range(0, 15);
    addr = 32'(word * 4);
    r = $urandom_range(0, 15);
    if (r == 0) addr = addr | 32'($urandom_range(1, 3));
    if (r == 1) addr = addr | 32'h0000_4000;
    if (r == 2) addr = $urandom();
    set_req(op, addr, (r == 3) ? 2'd3 : 2'($urandom_range(0, 2)),
            4'($urandom_range(0, 15)), $urandom(), 8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic        req, we, acc;
    logic [31:0] wm;
    rst_ni = 1'b0;
    tl_i   = '0;
    repeat (2) tick();

    // Reset release, with a request presented while reset is held.
    set_req(3'd4, 32'h0, 2'd2, 4'hF, 32'h0, 8'h0);
    repeat (2) begin
      @(negedge clk);
      check("hold_rst_a_ready", tl_o.a_ready, 1'b0);
    end
    tl_i.a_valid = 1'b0;
    @(negedge clk); #1;
    rst_ni = 1'b1;
    #2 check("release_a_ready_low", tl_o.a_ready, 1'b0);
    @(negedge clk);
    check("release_a_ready_high", tl_o.a_ready, 1'b1);
    tick();

    // Single fetch.
    tl_i.d_ready = 1'b1;
    issue(3'd4, 32'h0, 4'hF, 32'h0, 8'h0, req, we, wm);
    check("fetch_req", {req, we}, 2'b10);
    @(negedge clk);
    check("fetch_d_valid", tl_o.d_valid, 1'b1);
    check("fetch_opcode",  tl_o.d_opcode, 3'd1);
    check("fetch_data",    tl_o.d_data, 32'h0000_0013);
    check("fetch_error",   tl_o.d_error, 1'b0);
    tick();

    // Partial write then read back.
    issue(3'd1, 32'h4, 4'b0011, 32'hAABB_CCDD, 8'h1, req, we, wm);
    check("pp_wmask", wm, 32'h0000_FFFF);
    check("pp_we",    {req, we}, 2'b11);
    @(negedge clk);
    check("pp_ack", {tl_o.d_valid, tl_o.d_opcode, tl_o.d_data}, {1'b1, 3'd0, 32'h0});
    tick();
    issue(3'd4, 32'h4, 4'hF, 32'h0, 8'h2, req, we, wm);
    @(negedge clk);
    check("rd_back_data", tl_o.d_data, 32'h0000_CCDD);
    tick();

    // Backpressure: third request must wait for the first pop.
    tl_i.d_ready = 1'b0;
    issue(3'd4, 32'h0, 4'hF, 32'h0, 8'h1, req, we, wm);
    issue(3'd4, 32'h4, 4'hF, 32'h0, 8'h2, req, we, wm);
    set_req(3'd4, 32'h8, 2'd2, 4'hF, 32'h0, 8'h3);
    repeat (3) begin
      @(negedge clk);
      check("bp_full_a_ready", tl_o.a_ready, 1'b0);
      check("bp_head_data",    tl_o.d_data, 32'h0000_0013);
    end
    tick();
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    check("bp_pop1", {tl_o.d_source, tl_o.d_data, tl_o.a_ready}, {8'h1, 32'h0000_0013, 1'b0});
    tick();
    @(negedge clk);
    check("bp_pop2", {tl_o.d_source, tl_o.d_data, tl_o.a_ready}, {8'h2, 32'h0000_CCDD, 1'b1});
    tick();
    tl_i.a_valid = 1'b0;
    @(negedge clk);
    check("bp_pop3", {tl_o.d_valid, tl_o.d_source, tl_o.d_data}, {1'b1, 8'h3, 32'h0});
    tick();

    // Error requests.
    issue(3'd4, 32'h2, 4'hF, 32'h0, 8'h4, req, we, wm);
    check("err_unaligned_req", req, 1'b0);
    @(negedge clk);
    check("err_unaligned_rsp", {tl_o.d_error, tl_o.d_data}, {1'b1, 32'h0});
    tick();
    issue(3'd3, 32'h0, 4'hF, 32'h1234, 8'h5, req, we, wm);
    check("err_opcode_req", req, 1'b0);
    @(negedge clk);
    check("err_opcode_rsp", {tl_o.d_error, tl_o.d_opcode, tl_o.d_data}, {1'b1, 3'd0, 32'h0});
    tick();
    issue(3'd4, 32'h0000_4000, 4'hF, 32'h0, 8'h6, req, we, wm);
    check("err_oor_req", req, 1'b0);
    @(negedge clk);
    check("err_oor_rsp", {tl_o.d_error, tl_o.d_data}, {1'b1, 32'h0});
    tick();

    // Reset with two responses pending.
    tl_i.d_ready = 1'b0;
    issue(3'd4, 32'h0, 4'hF, 32'h0, 8'h7, req, we, wm);
    issue(3'd4, 32'h4, 4'hF, 32'h0, 8'h8, req, we, wm);
    #2 rst_ni = 1'b0;
    @(negedge clk);
    check("mid_rst_d_valid", tl_o.d_valid, 1'b0);
    @(negedge clk); #1;
    rst_ni = 1'b1;
    tl_i.d_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", {tl_o.d_valid, tl_o.a_ready}, 2'b01);
    end
    tick();

    // Randomized traffic, with one reset in the middle.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = tl_i.a_valid && tl_o.a_ready;
      if (c == 403) begin
        #1 rst_ni = 1'b1;
      end
      tick();
      if (acc || !tl_i.a_valid) begin
        if ($urandom_range(0, 2) != 0) rand_req();
        else tl_i.a_valid = 1'b0;
      end
      tl_i.d_ready = ($urandom_range(0, 3) != 0);
      if (c == 400) begin
        #2 rst_ni = 1'b0;
      end
    end
    tl_i.a_valid = 1'b0;
    tl_i.d_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("drain_empty", tl_o.d_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_sram_responder.md
TLUL_SRAM_RESPONDER -- requirements
Module: tlul_sram_responder

Interface
REQ-001 SHALL have parameter SramAw, default 12, meaning the SRAM word-address width (SRAM covers 2^SramAw 32-bit words from byte address 0).
REQ-002 SHALL have parameter ErrOnOor, default 1, meaning out-of-range addresses return d_error=1.
REQ-003 SHALL have port clk_i  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tl_i  input  tlul_pkg::tl_h2d_t  host A-channel plus d_ready (connects to ibex_tlul tl_i_o or tl_d_o).
REQ-006 SHALL have port tl_o  output  tlul_pkg::tl_d2h_t  D-channel plus a_ready (connects to ibex_tlul tl_i_i or tl_d_i).
REQ-007 SHALL have port sram_req_o  output  1  SRAM access strobe.
REQ-008 SHALL have port sram_we_o  output  1  SRAM write enable.
REQ-009 SHALL have port sram_addr_o  output  SramAw  word address, equal to a_address[SramAw+1:2].
REQ-010 SHALL have port sram_wdata_o  output  32  write data, equal to a_data.
REQ-011 SHALL have port sram_wmask_o  output  32  bit mask; byte i of the mask equals {8{a_mask[i]}}.
REQ-012 SHALL have port sram_rdata_i  input  32  read data, valid exactly one cycle after sram_req_o with sram_we_o=0.

Function
REQ-013 SHALL accept a request in a cycle where tl_i.a_valid and tl_o.a_ready are both 1.
REQ-014 SHALL hold at most 2 responses in flight (pipeline stage plus one skid entry).
REQ-015 SHALL drive a_ready = (occupancy < 2), registered and with no combinational path from d_ready.
REQ-016 SHALL decode opcodes as follows: Get gives AccessAckData; PutFullData and PutPartialData give AccessAck; any other opcode gives AccessAck with d_error=1.
REQ-017 SHALL mark a request as an error, and assert neither sram_req_o nor any write, when any of these holds: unsupported opcode; a_address[1:0]!=0; a_size>2; ErrOnOor=1 with a_address[31:SramAw+2]!=0.
REQ-018 SHALL, for a valid accepted request, assert sram_req_o combinationally in the accept cycle, with sram_we_o=1 for Put opcodes and 0 for Get.
REQ-019 SHALL echo the request's a_source and a_size on d_source and d_size, and drive d_param=0, d_sink=0 and d_user=TL_D_USER_DEFAULT.
REQ-020 SHALL give latency as follows: request accepted in cycle N gives d_valid=1 in cycle N+1 when no older response is pending.
REQ-021 SHALL, for a Get response presented in cycle N+1, drive d_data=sram_rdata_i live in that cycle.
REQ-022 SHALL, if a Get response is not popped in cycle N+1, capture sram_rdata_i at the end of N+1 and hold it stable until popped.
REQ-023 SHALL drive d_data=0 for AccessAck and for error responses.
REQ-024 SHALL pop the head response when d_valid and d_ready are both 1.
REQ-025 SHALL deliver responses strictly in acceptance order.
REQ-026 SHALL keep every D-channel field stable while d_valid=1 and d_ready=0.
REQ-027 SHALL, on a simultaneous accept and pop in one cycle, leave occupancy unchanged and keep ordering correct.
REQ-028 SHALL, when occupancy is 2, hold a_ready=0; a_ready SHALL return to 1 in the cycle after the first pop.
REQ-029 SHALL accept a new request in the same cycle a response is popped if a_ready was already 1.

Reset
REQ-030 SHALL, while rst_ni=0, drive: d_valid=0, a_ready=0, occupancy=0, sram_req_o=0, sram_we_o=0, and all D-channel fields 0 except d_user=TL_D_USER_DEFAULT.
REQ-031 SHALL set a_ready=1 in the first cycle after rst_ni deasserts.
REQ-032 SHALL, on reset asserted mid-transaction, discard in-flight responses with no d_valid pulse, and perform no SRAM access while rst_ni=0.

Verification
REQ-033 SHALL cover reset release: check a_ready=0 during reset and a_ready=1 one cycle after.
REQ-034 SHALL cover a single fetch: Get at address 0x0, source 0, SRAM word 0 = 0x00000013 -> next cycle d_valid=1, d_opcode=AccessAckData, d_data=0x00000013, d_error=0.
REQ-035 SHALL cover write then read: PutPartialData at 0x4 with data 0xAABBCCDD and mask 0b0011, then Get at 0x4 with prior content 0 -> wmask=0x0000FFFF and read data 0x0000CCDD.
REQ-036 SHALL cover backpressure: d_ready=0 while issuing 3 Gets to 0x0, 0x4, 0x8 -> only 2 accepted, a_ready=0; on release, data returns in order with the captured values unchanged.
REQ-037 SHALL cover error requests: Get at 0x2, opcode 3, and Get at address 1<<(SramAw+2) -> each returns d_error=1, d_data=0, and sram_req_o is never asserted.
REQ-038 SHALL cover reset asserted with 2 responses pending -> no d_valid after reset release, and a_ready=1 the following cycle.
